rnn_param_ram: RTL
==================

// Module: rnn_param_ram
// PURPOSE
//  Parametrised multi-channel parameter/state store for the RNN node. Holds NUM_CH parallel
//  word arrays (default 5: W,H,U,X,V) sharing one write address and one read address.
//  Adds over the previous store: per-channel write mask, read enable with valid flag, and a
//  sequential clear engine that zeroes one row per cycle, so the arrays map to block RAM.
//  Sits between the node loader (writes) and the RNN datapath (reads).
// PARAMETERS
//  NUM_CH  5    number of parallel channels (arrays)
//  DATA_W  32   word width per channel
//  DEPTH   512  rows per channel; a power of two, >= 2
//  ADDR_W  $clog2(DEPTH)  address width (derived; do not override)
// PORTS
//  clk       in   1               clock; all logic on rising edge
//  reset     in   1               synchronous, active-low (0 = reset); starts a clear sweep
//  clr_req   in   1               1-cycle pulse: start a clear sweep (ignored while busy)
//  busy      out  1               1 while the clear sweep runs
//  wr_en     in   1               write strobe
//  wr_addr   in   ADDR_W          write row
//  wr_mask   in   NUM_CH          per-channel write enable; bit c gates channel c
//  wr_data   in   NUM_CH*DATA_W   channel c in bits [c*DATA_W +: DATA_W]
//  rd_en     in   1               read strobe
//  rd_addr   in   ADDR_W          read row
//  rd_data   out  NUM_CH*DATA_W   registered read data, same packing as wr_data
//  rd_valid  out  1               rd_data holds the result of a read accepted on the previous cycle
// BEHAVIOUR
//  - Reset (reset==0 at a clock edge): rd_data=0, rd_valid=0, busy=1, state=CLEAR, clr_addr=0.
//    Array contents are not reset directly; the sweep that follows zeroes them.
//  - FSM: CLEAR -> IDLE after the row DEPTH-1 write. IDLE -> CLEAR on clr_req. No other states.
//  - CLEAR: each cycle writes 0 to every channel at row clr_addr, then clr_addr++. A sweep takes
//    exactly DEPTH cycles. busy drops on the cycle after row DEPTH-1 is cleared.
//  - While busy: wr_en and rd_en are ignored (writes dropped, rd_valid=0, rd_data holds).
//  - clr_req while busy: ignored. reset mid-sweep: the sweep restarts at row 0.
//  - IDLE write: on wr_en, channel c at wr_addr takes its wr_data slice iff wr_mask[c];
//    unmasked channels keep their value. wr_mask==0 is a legal no-op.
//  - IDLE read: on rd_en, rd_data <= row rd_addr on the next edge (latency 1); rd_valid=1 for
//    that cycle only. Without rd_en, rd_valid=0 and rd_data holds its last value.
//  - Same-cycle wr_en and rd_en to different rows: both complete independently.
//  - Same-cycle, same row: see CONFIGURATION.
//  - Addresses are always in range (ADDR_W bits, DEPTH a power of two); no wrap logic needed.
// CONFIGURATION
//  RNN_RAM_WR_BYPASS_EN defined: same-row same-cycle read returns new data for channels with
//    wr_mask[c]=1 and stored data for the rest (write-first, per channel).
//  Not defined: the same-row read returns the stored (pre-write) data for all channels (read-first).
// STRUCTURE
//  - Package rnn_ram_pkg: FSM state typedef {ST_IDLE, ST_CLEAR}; channel index constants
//    CH_W=0, CH_H=1, CH_U=2, CH_X=3, CH_V=4; default NUM_CH/DATA_W/DEPTH constants.
//  - Sub-module rnn_ram_bank (one channel): DATA_W x DEPTH array, one write port, one registered
//    read port, instantiated NUM_CH times in a generate loop. The top level owns the FSM,
//    clear-address counter, write-mux (clear vs user), rd_valid and the bypass logic.
// TESTING
//  1. Release reset; busy stays 1 for exactly 512 cycles; read rows 0, 255 and 511 -> all channels 0.
//  2. Write row 7, mask 5'b11111, data ch c = 32'hA0+c; read row 7 -> ch c = 32'hA0+c, rd_valid
//     for exactly 1 cycle, one cycle after rd_en.
//  3. Rewrite row 7 with mask 5'b00100, data 32'hDEAD in all slices; read -> only ch2=32'hDEAD,
//     other channels unchanged.
//  4. Same cycle: write row 9 = 32'h1234 (mask 5'b00011), read row 9 (old value 0) -> with macro
//     ch0,ch1=32'h1234 and others 0; without macro all channels 0.
//  5. clr_req after filling rows 0..3; issue wr_en and rd_en during the sweep -> writes dropped,
//     rd_valid stays 0; after busy falls, all rows read 0.
//  6. Assert reset at sweep cycle 100, release -> the sweep restarts; busy lasts a further 512 cycles.

Source files
------------

// File: rtl/rnn_ram_pkg.sv
// rnn_ram_pkg: shared FSM states, channel indices and default sizes for the RNN parameter store.
package rnn_ram_pkg;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    localparam int CH_W = 0;
    localparam int CH_H = 1;
    localparam int CH_U = 2;
    localparam int CH_X = 3;
    localparam int CH_V = 4;
    localparam int NUM_CH_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF = 512;
endpackage

// File: rtl/rnn_ram_bank.sv
// rnn_ram_bank: one channel, DATA_W x DEPTH array with one write port and one registered read port.
module rnn_ram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/rnn_param_ram.sv
// rnn_param_ram: NUM_CH-channel masked-write parameter store with a row-per-cycle clear sweep.
// Define RNN_RAM_WR_BYPASS_EN for write-first same-row reads; default is read-first.
module rnn_param_ram
    import rnn_ram_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_CH-1:0]        wr_mask,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     rd_valid
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t state, state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic clr_go, wr_go, rd_go;

    assign busy = state == ST_CLEAR;
    // Array writes are held off during reset so the restarted sweep owns the arrays.
    assign clr_go = reset && busy;
    assign wr_go = reset && !busy && wr_en;
    assign rd_go = reset && !busy && rd_en;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_CLEAR;
            clr_addr <= '0;
            rd_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            clr_addr <= busy ? clr_addr + 1'b1 : '0;
            rd_valid <= rd_go;
        end
    end

    always_comb begin
        state_nxt = state;
        state_nxt = busy ? ((clr_addr == LAST) ? ST_IDLE : ST_CLEAR) : (clr_req ? ST_CLEAR : ST_IDLE);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] q;
        rnn_ram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
            .clk(clk),
            .reset(reset),
            .we(clr_go || (wr_go && wr_mask[c])),
            .waddr(clr_go ? clr_addr : wr_addr),
            .wdata(clr_go ? '0 : wr_data[c*DATA_W +: DATA_W]),
            .re(rd_go),
            .raddr(rd_addr),
            .rdata(q)
        );
`ifdef RNN_RAM_WR_BYPASS_EN
        logic byp;
        logic [DATA_W-1:0] byp_d;
        // Bypass select and data are captured only on accepted reads so rd_data holds otherwise.
        always_ff @(posedge clk) begin
            if (!reset) begin
                byp <= 1'b0;
                byp_d <= '0;
            end else if (rd_go) begin
                byp <= wr_go && wr_mask[c] && (wr_addr == rd_addr);
                byp_d <= wr_data[c*DATA_W +: DATA_W];
            end
        end
        assign rd_data[c*DATA_W +: DATA_W] = byp ? byp_d : q;
`else
        assign rd_data[c*DATA_W +: DATA_W] = q;
`endif
    end
endmodule
